audio_packet_decoder: RTL and testbench

- Receive-side counterpart to the data-island audio packet generators.
- Consumes decoded 24-bit packet headers and four 56-bit subpackets; parses Audio Clock Regeneration packets (type 0x01) and 2-channel Audio Sample packets (type 0x02).
- Recovers N/CTS, L/R sample words, V/U bits and the two 192-bit IEC 60958 channel-status blocks.
- Sits after the data-island BCH/ECC decoder in the HDMI receive path; feeds an audio FIFO/DAC interface.

---
 rtl/hdmi_audio_pkg.sv | 33 +++
 rtl/channel_status_collector.sv | 96 +++++++++
 rtl/audio_packet_decoder.sv | 132 +++++++++++++
 tb/tb_audio_packet_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_audio_pkg.sv
// Shared constants for the HDMI data-island audio receive path: packet types,
// header/subpacket bit positions and the IEC 60958 block-sync state encoding.
package hdmi_audio_pkg;

    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;

    // Header bits: HB2[4] = block start, HB1[4] = layout, HB1[0] = subpacket 0 present
    localparam int HDR_B_BIT       = 20;
    localparam int HDR_LAYOUT_BIT  = 12;
    localparam int HDR_PRESENT_BIT = 8;

    // Sample subpacket: 24-bit word per channel, then {P,C,U,V} nibble per channel
    localparam int SP_WORD_W    = 24;
    localparam int SP_FLAG_BASE = 48;
    localparam int SP_FLAG_W    = 4;
    localparam int SP_C_L       = 50;
    localparam int SP_C_R       = 54;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } sync_state_e;

    function automatic logic [19:0] acr_n(input logic [55:0] sp);
        return {sp[35:32], sp[47:40], sp[55:48]};
    endfunction

    function automatic logic [19:0] acr_cts(input logic [55:0] sp);
        return {sp[11:8], sp[23:16], sp[31:24]};
    endfunction

endpackage

// File: rtl/channel_status_collector.sv
// Assembles per-frame C bits into two IEC 60958 channel-status blocks, tracking
// block alignment from the B flag and committing each complete block at once.
module channel_status_collector
    import hdmi_audio_pkg::*;
#(
    parameter int LEN = 192
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           strobe_i,
    input  logic           b_i,
    input  logic           c_l_i,
    input  logic           c_r_i,
    output logic [LEN-1:0] cs_left_o,
    output logic [LEN-1:0] cs_right_o,
    output logic           cs_valid_o,
    output logic           locked_o,
    output logic           sync_error_o
);

    localparam int CW = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    sync_state_e    state_q;
    logic [CW-1:0]  cnt_q;
    logic [LEN-1:0] shadow_l_q, shadow_r_q;
    logic [LEN-1:0] cs_left_q, cs_right_q;
    logic           cs_valid_q, sync_error_q;
    logic [LEN-1:0] commit_l_d, commit_r_d;

    // The final frame's C bit is merged on the fly so the block commits in the same edge
    always_comb begin
        commit_l_d       = shadow_l_q;
        commit_r_d       = shadow_r_q;
        commit_l_d[LAST] = c_l_i;
        commit_r_d[LAST] = c_r_i;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= UNLOCKED;
            cnt_q        <= '0;
            shadow_l_q   <= '0;
            shadow_r_q   <= '0;
            cs_left_q    <= '0;
            cs_right_q   <= '0;
            cs_valid_q   <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            cs_valid_q   <= 1'b0;
            sync_error_q <= 1'b0;
            if (strobe_i) begin
                case (state_q)
                    UNLOCKED: begin
                        if (b_i) begin
                            state_q       <= LOCKED;
                            cnt_q         <= CW'(1);
                            shadow_l_q[0] <= c_l_i;
                            shadow_r_q[0] <= c_r_i;
                        end
                    end
                    LOCKED: begin
                        if (b_i) begin
                            // A B flag mid-block means we lost alignment; restart on it
                            sync_error_q  <= (cnt_q != '0);
                            cnt_q         <= CW'(1);
                            shadow_l_q[0] <= c_l_i;
                            shadow_r_q[0] <= c_r_i;
                        end else if (cnt_q == '0) begin
                            sync_error_q <= 1'b1;
                            state_q      <= UNLOCKED;
                        end else begin
                            shadow_l_q[cnt_q] <= c_l_i;
                            shadow_r_q[cnt_q] <= c_r_i;
                            if (cnt_q == LAST) begin
                                cs_left_q  <= commit_l_d;
                                cs_right_q <= commit_r_d;
                                cs_valid_q <= 1'b1;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign cs_left_o    = cs_left_q;
    assign cs_right_o   = cs_right_q;
    assign cs_valid_o   = cs_valid_q;
    assign locked_o     = (state_q == LOCKED);
    assign sync_error_o = sync_error_q;

endmodule

// File: rtl/audio_packet_decoder.sv
// Parses ACR and 2-channel audio sample data-island packets into N/CTS, a
// handshaked sample register and the recovered channel-status blocks.
module audio_packet_decoder
    import hdmi_audio_pkg::*;
#(
    parameter int CHANNEL_STATUS_LENGTH = 192,
    parameter bit DROP_ON_PARITY_ERROR  = 1'b1
) (
    input  logic                             clk_pixel,
    input  logic                             reset,
    input  logic                             packet_valid,
    input  logic [23:0]                      header,
    input  logic [3:0][55:0]                 sub,
    output logic                             sample_valid,
    input  logic                             sample_ready,
    output logic [1:0][23:0]                 audio_sample_word,
    output logic [1:0]                       valid_bit,
    output logic [1:0]                       user_data_bit,
    output logic [1:0]                       parity_error,
    output logic                             sample_overflow,
    output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_left,
    output logic [CHANNEL_STATUS_LENGTH-1:0] channel_status_right,
    output logic                             channel_status_valid,
    output logic                             locked,
    output logic                             sync_error,
    output logic [19:0]                      N,
    output logic [19:0]                      CTS,
    output logic                             acr_valid,
    output logic                             acr_error
);

    logic             is_acr, acr_consistent, is_sample, drop_parity, stall;
    logic [1:0][23:0] word_d;
    logic [1:0][3:0]  flags_d;
    logic [1:0]       perr_d;
    logic             unused_header;

    logic [1:0][23:0] word_q;
    logic [1:0]       v_q, u_q, perr_q;
    logic             sample_valid_q, overflow_q;
    logic [19:0]      n_q, cts_q;
    logic             acr_valid_q, acr_error_q;

    assign is_acr         = packet_valid && (header[7:0] == PKT_ACR);
    assign acr_consistent = (sub[1] == sub[0]) && (sub[2] == sub[0]) && (sub[3] == sub[0]);
    assign is_sample      = packet_valid && (header[7:0] == PKT_AUDIO_SAMPLE)
                            && !header[HDR_LAYOUT_BIT] && header[HDR_PRESENT_BIT];
    assign unused_header  = ^{header[23:21], header[19:13], header[11:9]};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_chan
        assign word_d[gi]  = sub[0][gi*SP_WORD_W +: SP_WORD_W];
        assign flags_d[gi] = sub[0][SP_FLAG_BASE + gi*SP_FLAG_W +: SP_FLAG_W];
        assign perr_d[gi]  = ^{word_d[gi], flags_d[gi]};
    end

    assign drop_parity = DROP_ON_PARITY_ERROR && (|perr_d);
    assign stall       = sample_valid_q && !sample_ready;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            word_q         <= '0;
            v_q            <= '0;
            u_q            <= '0;
            perr_q         <= '0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            n_q            <= '0;
            cts_q          <= '0;
            acr_valid_q    <= 1'b0;
            acr_error_q    <= 1'b0;
        end else begin
            acr_valid_q <= 1'b0;
            acr_error_q <= 1'b0;
            if (is_acr) begin
                if (acr_consistent) begin
                    n_q         <= acr_n(sub[0]);
                    cts_q       <= acr_cts(sub[0]);
                    acr_valid_q <= 1'b1;
                end else begin
                    acr_error_q <= 1'b1;
                end
            end

            if (sample_valid_q && sample_ready) begin
                sample_valid_q <= 1'b0;
            end
            // A parity-dropped sample still reports its error so the fault is visible
            if (is_sample) begin
                if (drop_parity) begin
                    perr_q <= perr_d;
                end else if (stall) begin
                    overflow_q <= 1'b1;
                end else begin
                    word_q         <= word_d;
                    v_q            <= {flags_d[1][0], flags_d[0][0]};
                    u_q            <= {flags_d[1][1], flags_d[0][1]};
                    perr_q         <= perr_d;
                    sample_valid_q <= 1'b1;
                end
            end
        end
    end

    channel_status_collector #(
        .LEN(CHANNEL_STATUS_LENGTH)
    ) u_csc (
        .clk          (clk_pixel),
        .srst         (reset),
        .strobe_i     (is_sample),
        .b_i          (header[HDR_B_BIT]),
        .c_l_i        (sub[0][SP_C_L]),
        .c_r_i        (sub[0][SP_C_R]),
        .cs_left_o    (channel_status_left),
        .cs_right_o   (channel_status_right),
        .cs_valid_o   (channel_status_valid),
        .locked_o     (locked),
        .sync_error_o (sync_error)
    );

    assign sample_valid      = sample_valid_q;
    assign audio_sample_word = word_q;
    assign valid_bit         = v_q;
    assign user_data_bit     = u_q;
    assign parity_error      = perr_q;
    assign sample_overflow   = overflow_q;
    assign N                 = n_q;
    assign CTS               = cts_q;
    assign acr_valid         = acr_valid_q;
    assign acr_error         = acr_error_q;

endmodule

// File: tb/tb_audio_packet_decoder.sv
// Randomized scenario bench for audio_packet_decoder against a queue-based
// reference model of the packet rules.
module tb_audio_packet_decoder;

    logic             clk_pixel = 1'b0;
    logic             reset = 1'b1;
    logic             packet_valid = 1'b0;
    logic [23:0]      header = '0;
    logic [3:0][55:0] sub = '0;
    logic             sample_ready = 1'b0;
    logic             sample_valid, sample_overflow, channel_status_valid;
    logic             locked, sync_error, acr_valid, acr_error;
    logic [1:0][23:0] audio_sample_word;
    logic [1:0]       valid_bit, user_data_bit, parity_error;
    logic [191:0]     channel_status_left, channel_status_right;
    logic [19:0]      N, CTS;

    always #5 clk_pixel = ~clk_pixel;

    audio_packet_decoder dut (
        .clk_pixel(clk_pixel), .reset(reset), .packet_valid(packet_valid),
        .header(header), .sub(sub), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .audio_sample_word(audio_sample_word),
        .valid_bit(valid_bit), .user_data_bit(user_data_bit),
        .parity_error(parity_error), .sample_overflow(sample_overflow),
        .channel_status_left(channel_status_left),
        .channel_status_right(channel_status_right),
        .channel_status_valid(channel_status_valid), .locked(locked),
        .sync_error(sync_error), .N(N), .CTS(CTS), .acr_valid(acr_valid),
        .acr_error(acr_error)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    bit          m_sv, m_ovf, m_acr_v, m_acr_e, m_inblk, m_csv, m_serr;
    bit [23:0]   m_l, m_r;
    bit [1:0]    m_v, m_u, m_pe;
    bit [19:0]   m_n, m_cts;
    bit [191:0]  m_csl, m_csr;
    bit          ql[$];
    bit          qr[$];

    task automatic model_clear();
        m_sv = 0; m_ovf = 0; m_acr_v = 0; m_acr_e = 0; m_inblk = 0; m_csv = 0; m_serr = 0;
        m_l = 0; m_r = 0; m_v = 0; m_u = 0; m_pe = 0; m_n = 0; m_cts = 0;
        m_csl = 0; m_csr = 0; ql.delete(); qr.delete();
    endtask

    task automatic model_cs(input bit b, input bit cl, input bit cr);
        if (!m_inblk) begin
            if (b) begin
                m_inblk = 1; ql.delete(); qr.delete(); ql.push_back(cl); qr.push_back(cr);
            end
        end else if (b) begin
            if (ql.size() != 0) m_serr = 1;
            ql.delete(); qr.delete(); ql.push_back(cl); qr.push_back(cr);
        end else if (ql.size() == 0) begin
            m_serr = 1; m_inblk = 0;
        end else begin
            ql.push_back(cl); qr.push_back(cr);
            if (ql.size() == 192) begin
                for (int k = 0; k < 192; k++) begin
                    m_csl[k] = ql[k]; m_csr[k] = qr[k];
                end
                m_csv = 1; ql.delete(); qr.delete();
            end
        end
    endtask

    task automatic model_step(input logic pv, input logic [23:0] hdr,
                              input logic [3:0][55:0] s, input logic rdy);
        bit       full;
        bit [1:0] pe;
        bit [7:0] sb [7];
        for (int i = 0; i < 7; i++) sb[i] = s[0][8*i +: 8];
        m_acr_v = 0; m_acr_e = 0; m_csv = 0; m_serr = 0;
        full = m_sv && !rdy;
        if (m_sv && rdy) m_sv = 0;
        if (pv && hdr[7:0] == 8'h01) begin
            if (s[1] == s[0] && s[2] == s[0] && s[3] == s[0]) begin
                m_n   = {sb[4][3:0], sb[5], sb[6]};
                m_cts = {sb[1][3:0], sb[2], sb[3]};
                m_acr_v = 1;
            end else begin
                m_acr_e = 1;
            end
        end
        if (pv && hdr[7:0] == 8'h02 && !hdr[12] && hdr[8]) begin
            pe[0] = ($countones({s[0][23:0], s[0][51:48]}) % 2) != 0;
            pe[1] = ($countones({s[0][47:24], s[0][55:52]}) % 2) != 0;
            if (pe != 0) begin
                m_pe = pe;
            end else if (full) begin
                m_ovf = 1;
            end else begin
                m_sv = 1; m_l = s[0][23:0]; m_r = s[0][47:24];
                m_v = {s[0][52], s[0][48]}; m_u = {s[0][53], s[0][49]}; m_pe = 0;
            end
            model_cs(hdr[20], s[0][50], s[0][54]);
        end
    endtask

    task automatic tick(input logic pv, input logic [23:0] hdr, input logic [3:0][55:0] s);
        @(negedge clk_pixel);
        packet_valid = pv; header = hdr; sub = s;
        @(posedge clk_pixel);
        model_step(pv, hdr, s, sample_ready);
        #1;
        packet_valid = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 24'h0, '0);
    endtask

    function automatic logic [55:0] acr_sub(input logic [19:0] n, input logic [19:0] cts);
        return {n[7:0], n[15:8], 4'h0, n[19:16], cts[7:0], cts[15:8], 4'h0, cts[19:16], 8'h00};
    endfunction

    function automatic logic [23:0] aud_hdr(input logic b, input logic layout, input logic present);
        return {3'b000, b, 4'b0000, 3'b000, layout, 3'b000, present, 8'h02};
    endfunction

    // vu = {U_R, V_R, U_L, V_L}; bad_* inverts the otherwise-even parity bit
    function automatic logic [55:0] sample_sub(input logic [23:0] l, input logic [23:0] r,
                                               input logic [3:0] vu, input logic cl, input logic cr,
                                               input logic bad_l, input logic bad_r);
        logic pl, pr;
        pl = (($countones({l, vu[0], vu[1], cl}) % 2) != 0) ^ bad_l;
        pr = (($countones({r, vu[2], vu[3], cr}) % 2) != 0) ^ bad_r;
        return {pr, cr, vu[3], vu[2], pl, cl, vu[1], vu[0], r, l};
    endfunction

    task automatic send_sample(input logic b, input logic [23:0] l, input logic [23:0] r,
                               input logic [3:0] vu, input logic cl, input logic cr,
                               input logic bad_l, input logic bad_r);
        logic [3:0][55:0] s;
        s = '0;
        s[0] = sample_sub(l, r, vu, cl, cr, bad_l, bad_r);
        tick(1'b1, aud_hdr(b, 1'b0, 1'b1), s);
    endtask

    task automatic send_rand(input logic b, input logic cl, input logic cr);
        send_sample(b, 24'($urandom), 24'($urandom), 4'($urandom), cl, cr, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        reset = 1'b1; packet_valid = 1'b0;
        repeat (2) @(posedge clk_pixel);
        model_clear();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (sample_valid !== 1'b0 || sample_overflow !== 1'b0 || parity_error !== 2'b00) begin
            mismatched++; $display("FAIL reset_sample: valid=%b ovf=%b perr=%b want 0", sample_valid, sample_overflow, parity_error); end
        compared++; if (N !== 20'd0 || CTS !== 20'd0 || acr_valid !== 1'b0 || acr_error !== 1'b0) begin
            mismatched++; $display("FAIL reset_acr: N=%0d CTS=%0d v=%b e=%b want 0", N, CTS, acr_valid, acr_error); end
        compared++; if (locked !== 1'b0 || channel_status_left !== '0 || channel_status_right !== '0 || channel_status_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_cs: locked=%b csv=%b want 0", locked, channel_status_valid); end
        $display("reset: outputs checked");
    endtask

    task automatic test_acr();
        logic [3:0][55:0] s;
        logic [19:0] n, cts;
        for (int i = 0; i < 4; i++) s[i] = acr_sub(20'd6144, 20'd74250);
        tick(1'b1, 24'h000001, s);
        $display("acr: N=%0d CTS=%0d v=%b e=%b", N, CTS, acr_valid, acr_error);
        compared++; if (acr_valid !== 1'b1 || acr_error !== 1'b0 || N !== 20'd6144 || CTS !== 20'd74250) begin
            mismatched++; $display("FAIL acr_good: N=%0d CTS=%0d v=%b e=%b want 6144 74250 1 0", N, CTS, acr_valid, acr_error); end
        s[2][20] = ~s[2][20];
        tick(1'b1, 24'h000001, s);
        $display("acr corrupted: N=%0d CTS=%0d v=%b e=%b", N, CTS, acr_valid, acr_error);
        compared++; if (acr_valid !== 1'b0 || acr_error !== 1'b1 || N !== 20'd6144 || CTS !== 20'd74250) begin
            mismatched++; $display("FAIL acr_bad: N=%0d CTS=%0d v=%b e=%b want 6144 74250 0 1", N, CTS, acr_valid, acr_error); end
        idle();
        compared++; if (acr_error !== 1'b0 || acr_valid !== 1'b0) begin
            mismatched++; $display("FAIL acr_strobe_clear: v=%b e=%b want 0 0", acr_valid, acr_error); end
        for (int t = 0; t < 10; t++) begin
            n = 20'($urandom); cts = 20'($urandom);
            for (int i = 0; i < 4; i++) s[i] = acr_sub(n, cts);
            if ($urandom_range(0, 1) == 1) s[$urandom_range(1, 3)][$urandom_range(0, 55)] ^= 1'b1;
            tick(1'b1, 24'h000001, s);
            $display("acr rand: N=%0d CTS=%0d v=%b e=%b", N, CTS, acr_valid, acr_error);
            compared++; if (acr_valid !== m_acr_v || acr_error !== m_acr_e || N !== m_n || CTS !== m_cts) begin
                mismatched++; $display("FAIL acr_rand: N=%0d CTS=%0d v=%b e=%b want %0d %0d %b %b",
                                       N, CTS, acr_valid, acr_error, m_n, m_cts, m_acr_v, m_acr_e); end
        end
    endtask

    task automatic test_sample();
        sample_ready = 1'b1;
        send_sample(1'b0, 24'h123456, 24'hABCDEF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("sample: valid=%b L=%h R=%h perr=%b", sample_valid, audio_sample_word[0], audio_sample_word[1], parity_error);
        compared++; if (sample_valid !== 1'b1 || audio_sample_word[0] !== 24'h123456 || audio_sample_word[1] !== 24'hABCDEF || parity_error !== 2'b00) begin
            mismatched++; $display("FAIL sample_basic: valid=%b L=%h R=%h perr=%b want 1 123456 abcdef 00",
                                   sample_valid, audio_sample_word[0], audio_sample_word[1], parity_error); end
        idle();
        compared++; if (sample_valid !== 1'b0) begin
            mismatched++; $display("FAIL sample_consumed: valid=%b want 0", sample_valid); end
        send_sample(1'b0, 24'h123456, 24'hABCDEF, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("sample bad P_L: valid=%b perr=%b", sample_valid, parity_error);
        compared++; if (sample_valid !== 1'b0 || parity_error !== 2'b01) begin
            mismatched++; $display("FAIL sample_parity: valid=%b perr=%b want 0 01", sample_valid, parity_error); end
        for (int t = 0; t < 16; t++) begin
            sample_ready = 1'($urandom_range(0, 1));
            send_sample(1'b0, 24'($urandom), 24'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            $display("sample rand: valid=%b L=%h R=%h V=%b U=%b perr=%b ovf=%b", sample_valid,
                     audio_sample_word[0], audio_sample_word[1], valid_bit, user_data_bit, parity_error, sample_overflow);
            compared++; if (sample_valid !== m_sv || audio_sample_word[0] !== m_l || audio_sample_word[1] !== m_r ||
                            valid_bit !== m_v || user_data_bit !== m_u || parity_error !== m_pe ||
                            sample_overflow !== m_ovf || locked !== 1'b0) begin
                mismatched++; $display("FAIL sample_rand: valid=%b L=%h R=%h V=%b U=%b perr=%b ovf=%b want %b %h %h %b %b %b %b",
                                       sample_valid, audio_sample_word[0], audio_sample_word[1], valid_bit, user_data_bit,
                                       parity_error, sample_overflow, m_sv, m_l, m_r, m_v, m_u, m_pe, m_ovf); end
        end
        sample_ready = 1'b1;
    endtask

    task automatic test_channel_status();
        for (int k = 0; k < 192; k++) begin
            send_rand(k == 0, 1'(k % 2), 1'b1);
            compared++; if (locked !== 1'b1 || sync_error !== 1'b0 || channel_status_valid !== (k == 191)) begin
                mismatched++; $display("FAIL cs_frame%0d: locked=%b serr=%b csv=%b", k, locked, sync_error, channel_status_valid); end
        end
        $display("cs block: csv=%b left=%h right=%h", channel_status_valid, channel_status_left, channel_status_right);
        compared++; if (channel_status_left !== {96{2'b10}} || channel_status_right !== {192{1'b1}}) begin
            mismatched++; $display("FAIL cs_block: left=%h right=%h", channel_status_left, channel_status_right); end
    endtask

    task automatic test_resync();
        for (int k = 0; k < 100; k++) send_rand(k == 0, 1'($urandom), 1'($urandom));
        send_rand(1'b1, 1'($urandom), 1'($urandom));
        $display("resync inject: serr=%b csv=%b locked=%b", sync_error, channel_status_valid, locked);
        compared++; if (sync_error !== 1'b1 || channel_status_valid !== 1'b0 || locked !== 1'b1) begin
            mismatched++; $display("FAIL resync_inject: serr=%b csv=%b locked=%b want 1 0 1", sync_error, channel_status_valid, locked); end
        for (int j = 0; j < 191; j++) begin
            send_rand(1'b0, 1'($urandom), 1'($urandom));
            compared++; if (channel_status_valid !== (j == 190) || sync_error !== 1'b0 || locked !== 1'b1) begin
                mismatched++; $display("FAIL resync_frame%0d: csv=%b serr=%b locked=%b", j, channel_status_valid, sync_error, locked); end
        end
        $display("resync commit: left=%h right=%h", channel_status_left, channel_status_right);
        compared++; if (channel_status_left !== m_csl || channel_status_right !== m_csr) begin
            mismatched++; $display("FAIL resync_block: left=%h right=%h want %h %h", channel_status_left, channel_status_right, m_csl, m_csr); end
        send_rand(1'b0, 1'b0, 1'b0);
        $display("missing B: serr=%b locked=%b", sync_error, locked);
        compared++; if (sync_error !== 1'b1 || locked !== 1'b0) begin
            mismatched++; $display("FAIL missing_b: serr=%b locked=%b want 1 0", sync_error, locked); end
    endtask

    task automatic test_overflow();
        do_reset();
        sample_ready = 1'b0;
        send_sample(1'b0, 24'h00AAAA, 24'h00BBBB, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        send_sample(1'b0, 24'h111111, 24'h222222, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("overflow: valid=%b L=%h ovf=%b", sample_valid, audio_sample_word[0], sample_overflow);
        compared++; if (sample_valid !== 1'b1 || audio_sample_word[0] !== 24'h00AAAA || audio_sample_word[1] !== 24'h00BBBB || sample_overflow !== 1'b1) begin
            mismatched++; $display("FAIL overflow_hold: valid=%b L=%h R=%h ovf=%b want 1 00aaaa 00bbbb 1",
                                   sample_valid, audio_sample_word[0], audio_sample_word[1], sample_overflow); end
        sample_ready = 1'b1;
        send_sample(1'b0, 24'h333333, 24'h444444, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("consume+load: valid=%b L=%h ovf=%b", sample_valid, audio_sample_word[0], sample_overflow);
        compared++; if (sample_valid !== 1'b1 || audio_sample_word[0] !== 24'h333333 || audio_sample_word[1] !== 24'h444444 ||
                        valid_bit !== 2'b11 || sample_overflow !== 1'b1) begin
            mismatched++; $display("FAIL consume_load: valid=%b L=%h R=%h V=%b ovf=%b want 1 333333 444444 11 1",
                                   sample_valid, audio_sample_word[0], audio_sample_word[1], valid_bit, sample_overflow); end
        idle();
        compared++; if (sample_valid !== 1'b0 || sample_overflow !== 1'b1) begin
            mismatched++; $display("FAIL overflow_sticky: valid=%b ovf=%b want 0 1", sample_valid, sample_overflow); end
    endtask

    task automatic test_ignored();
        logic [3:0][55:0] s;
        do_reset();
        sample_ready = 1'b0;
        send_sample(1'b0, 24'h0F0F0F, 24'hF0F0F0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        s = '0;
        s[0] = sample_sub(24'h777777, 24'h888888, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            if (t == 0) tick(1'b1, aud_hdr(1'b1, 1'b1, 1'b1), s);
            else if (t == 1) tick(1'b1, aud_hdr(1'b1, 1'b0, 1'b0), s);
            else tick(1'b1, {aud_hdr(1'b1, 1'b0, 1'b1)[23:8], 8'h03}, s);
            $display("ignored %0d: valid=%b L=%h ovf=%b locked=%b", t, sample_valid, audio_sample_word[0], sample_overflow, locked);
            compared++; if (sample_valid !== 1'b1 || audio_sample_word[0] !== 24'h0F0F0F || sample_overflow !== 1'b0 ||
                            locked !== 1'b0 || acr_error !== 1'b0) begin
                mismatched++; $display("FAIL ignored_%0d: valid=%b L=%h ovf=%b locked=%b want 1 0f0f0f 0 0",
                                       t, sample_valid, audio_sample_word[0], sample_overflow, locked); end
        end
        sample_ready = 1'b1;
        idle();
    endtask

    task automatic test_reset_midblock();
        for (int k = 0; k < 192; k++) send_rand(k == 0, 1'($urandom), 1'($urandom));
        compared++; if (channel_status_valid !== 1'b1 || channel_status_left !== m_csl || channel_status_right !== m_csr) begin
            mismatched++; $display("FAIL pre_reset_block: csv=%b left=%h want %h", channel_status_valid, channel_status_left, m_csl); end
        for (int k = 0; k < 50; k++) send_rand(k == 0, 1'($urandom), 1'($urandom));
        do_reset();
        $display("mid-block reset: locked=%b left=%h right=%h", locked, channel_status_left, channel_status_right);
        compared++; if (locked !== 1'b0 || channel_status_left !== '0 || channel_status_right !== '0 ||
                        sample_valid !== 1'b0 || N !== 20'd0) begin
            mismatched++; $display("FAIL midblock_reset: locked=%b valid=%b N=%0d want all 0", locked, sample_valid, N); end
        for (int k = 0; k < 5; k++) begin
            send_rand(1'b0, 1'($urandom), 1'($urandom));
            compared++; if (locked !== 1'b0 || sync_error !== 1'b0) begin
                mismatched++; $display("FAIL unlocked_%0d: locked=%b serr=%b want 0 0", k, locked, sync_error); end
        end
        for (int k = 0; k < 192; k++) begin
            send_rand(k == 0, 1'($urandom), 1'($urandom));
            compared++; if (locked !== 1'b1 || channel_status_valid !== (k == 191)) begin
                mismatched++; $display("FAIL relock_%0d: locked=%b csv=%b", k, locked, channel_status_valid); end
        end
        $display("relock commit: left=%h right=%h", channel_status_left, channel_status_right);
        compared++; if (channel_status_left !== m_csl || channel_status_right !== m_csr) begin
            mismatched++; $display("FAIL relock_block: left=%h right=%h want %h %h", channel_status_left, channel_status_right, m_csl, m_csr); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_acr();
        test_sample();
        test_channel_status();
        test_resync();
        test_overflow();
        test_ignored();
        test_reset_midblock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
